audio_sample_recorder: RTL and testbench
========================================

# audio_sample_recorder

Captures microphone samples from the audio controller's input FIFO, mixes left/right to mono, quantizes them to the 6-bit unsigned song format, and writes them sequentially into the song RAM's write port. It is the write-side counterpart of the song playback path: the playback path reads the 6-bit RAM at audio rate, and this block fills the same RAM from live audio.

## Interface
- `ADDR_W`, 20, RAM address width.
- `DEPTH`, 633868, number of RAM words recorded per take (addresses 0..DEPTH-1).
- `SAMPLE_W`, 6, stored sample width.
- `DECIM`, 1, keep one of every DECIM popped samples (1 = keep all).

Ports:
- `CLOCK_50`  in  1  system clock, one clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin a new take at address 0.
- `stop`  in  1  one-cycle pulse: end the take early.
- `audio_in_available`  in  1  controller input FIFO non-empty.
- `left_channel_audio_in`  in  32  signed left sample, valid while available.
- `right_channel_audio_in`  in  32  signed right sample, valid while available.
- `read_audio_in`  out  1  one-cycle FIFO pop strobe.
- `ram_addr`  out  ADDR_W  RAM write address.
- `ram_data`  out  SAMPLE_W  RAM write data.
- `ram_wren`  out  1  RAM write enable, one cycle per word.
- `busy`  out  1  high in CAPTURE.
- `done`  out  1  high in DONE.
- `sample_count`  out  ADDR_W  words written in the current or last take.

## Operation
- States: IDLE, CAPTURE, DONE. Reset enters IDLE.
- Accept rule (every state): `audio_in_available && !read_audio_in` latches L/R into registers. `read_audio_in` goes high on the next cycle for exactly one cycle. Samples accepted in IDLE/DONE are discarded, which keeps the FIFO fresh.
- Decimation counter (0..DECIM-1) advances on each accept in CAPTURE. Only an accept with counter==0 is marked for write. The counter clears on entry to CAPTURE.
- Quantize: `sum = sext(L)+sext(R)` (33-bit signed). `q = sum[32:32-SAMPLE_W+1]` with MSB inverted, giving offset-binary unsigned.
- Write: the cycle after a marked accept, `ram_wren=1`, `ram_data=q`, `ram_addr=sample_count`. `sample_count` increments in the same cycle.
- Transitions:
  - IDLE/DONE → CAPTURE on `start`; `sample_count` clears to 0.
  - CAPTURE → DONE when the write to address DEPTH-1 issues, or on `stop`.
  - CAPTURE + `start` restarts at address 0.
  - `start` and `stop` in the same cycle: start wins.
- A write already marked when stop/full occurs still completes on the following cycle. No further marks are made.
- `sample_count` holds its value in DONE; `done` stays high until the next `start`.
- `ram_addr` never exceeds DEPTH-1. There is no wrap-around within a take.

## Timing
- Reset (async assert, sync release): state=IDLE, `read_audio_in`=0, `ram_wren`=0, `ram_addr`=0, `ram_data`=0, `busy`=0, `done`=0, `sample_count`=0, decim counter=0.
- Reset mid-take aborts immediately. RAM contents are untouched beyond the last completed write.
- Latency: accept in cycle N → `read_audio_in` and `ram_wren` both high in N+1. At most one accept per 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- `busy` and `done` change the cycle after the triggering event.

## Structure
- Shared package/header `audio_rec_pkg`:
  - state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2);
  - `SONG_DEPTH`=633868;
  - `SONG_SAMPLE_W`=6.
  - The playback path uses the same constants.
- One combinational sub-module `audio_sample_quantizer` (L, R → q), parameterized by SAMPLE_W and reused by any future monitoring path.
- FSM, accept/pop pipeline and address counter stay in the top module.

## Test plan
- Reset/idle: hold `resetn`=0, then release. Drive available=1 continuously in IDLE → `read_audio_in` pulses every 2nd cycle, `ram_wren` never asserts, all outputs 0.
- Quantizer values: L=R=0 → `ram_data`=32. L=R=32'h4000_0000 → 48. L=R=32'h8000_0000 → 0. L=32'h7FFF_FFFF, R=0 → 47.
- Full take with DEPTH=8, DECIM=1: `start`, then 10 samples offered → 8 writes at addresses 0..7. `done`=1 the cycle after the write to 7. `sample_count`=8. The last 2 samples are popped but not written.
- Decimation, DECIM=3: 9 samples in CAPTURE → 3 writes (samples 0, 3, 6) at addresses 0, 1, 2.
- Stop and restart: `stop` the cycle after an accept → that write (addr k) completes, then DONE with `sample_count`=k+1. Then `start`+`stop` together → CAPTURE, `sample_count`=0.
- Async reset mid-take at addr 5 → `ram_wren`, `busy` and `sample_count` drop to 0 immediately, state IDLE.

Source files
------------

// File: rtl/audio_rec_pkg.sv
// Constants and state encoding shared by the song record and playback paths.
package audio_rec_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } state_e;

    localparam int unsigned SONG_DEPTH    = 633868;
    localparam int unsigned SONG_SAMPLE_W = 6;

endpackage

// File: rtl/audio_sample_quantizer.sv
// Mixes a signed stereo pair to mono and keeps the top SAMPLE_W bits as offset binary.
module audio_sample_quantizer #(
    parameter int unsigned SAMPLE_W = 6
) (
    input  logic [31:0]         left,
    input  logic [31:0]         right,
    output logic [SAMPLE_W-1:0] q
);

    logic signed [32:0]   sum;
    logic [SAMPLE_W-1:0]  top;

    always_comb begin
        sum = {left[31], left} + {right[31], right};
        top = SAMPLE_W'(sum >>> (33 - SAMPLE_W));
        // Flipping the sign bit turns two's complement into offset binary.
        q   = {~top[SAMPLE_W-1], top[SAMPLE_W-2:0]};
    end

endmodule

// File: rtl/audio_sample_recorder.sv
// Pops stereo samples from the audio input FIFO and writes quantized mono words
// sequentially into the song RAM, one take at a time.
module audio_sample_recorder
    import audio_rec_pkg::*;
#(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DEPTH    = SONG_DEPTH,
    parameter int unsigned SAMPLE_W = SONG_SAMPLE_W,
    parameter int unsigned DECIM    = 1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [SAMPLE_W-1:0] ram_data,
    output logic                ram_wren,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   sample_count
);

    localparam int unsigned        CNT_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   DECIM_LAST = CNT_W'(DECIM - 1);

    state_e              state;
    logic [CNT_W-1:0]    decim_cnt;
    logic [SAMPLE_W-1:0] q;
    logic                accept;
    logic                full;
    logic                mark;

    audio_sample_quantizer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_quant (
        .left  (left_channel_audio_in),
        .right (right_channel_audio_in),
        .q     (q)
    );

    always_comb begin
        accept = audio_in_available && !read_audio_in;
        full   = ram_wren && (ram_addr == LAST_ADDR);
        // A start/stop/full cycle never marks; the take is being reset or closed.
        mark   = accept && (state == StCapture) && (decim_cnt == '0)
                 && !start && !stop && !full;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= StIdle;
            read_audio_in <= 1'b0;
            ram_wren      <= 1'b0;
            ram_addr      <= '0;
            ram_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sample_count  <= '0;
            decim_cnt     <= '0;
        end else begin
            read_audio_in <= accept;
            ram_wren      <= mark;
            if (mark) begin
                ram_addr <= sample_count;
                ram_data <= q;
            end

            if (accept && state == StCapture) begin
                decim_cnt <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + CNT_W'(1);
            end

            if (start) begin
                sample_count <= '0;
            end else if (ram_wren) begin
                sample_count <= sample_count + ADDR_W'(1);
            end

            if (start) begin
                state     <= StCapture;
                decim_cnt <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
            end else if (state == StCapture && (stop || full)) begin
                state <= StDone;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_recorder.sv
// Directed take sequence with random audio, checked against a FIFO/RAM reference model.
module tb_audio_sample_recorder;

    localparam int unsigned AW = 20;
    localparam int unsigned SW = 6;
    localparam int unsigned D  = 8;

    logic          clk = 1'b0;
    logic          resetn, start, stop, avail;
    logic [31:0]   lch, rch;

    logic          a_read, a_wren, a_busy, a_done;
    logic [AW-1:0] a_addr, a_count;
    logic [SW-1:0] a_data;
    logic          b_read, b_wren, b_busy, b_done;
    logic [AW-1:0] b_addr, b_count;
    logic [SW-1:0] b_data;

    always #5 clk = ~clk;

    audio_sample_recorder #(.ADDR_W(AW), .DEPTH(D), .SAMPLE_W(SW), .DECIM(1)) u_dut (
        .CLOCK_50 (clk), .resetn (resetn), .start (start), .stop (stop),
        .audio_in_available (avail), .left_channel_audio_in (lch),
        .right_channel_audio_in (rch), .read_audio_in (a_read), .ram_addr (a_addr),
        .ram_data (a_data), .ram_wren (a_wren), .busy (a_busy), .done (a_done),
        .sample_count (a_count)
    );

    audio_sample_recorder #(.ADDR_W(AW), .DEPTH(D), .SAMPLE_W(SW), .DECIM(3)) u_dut3 (
        .CLOCK_50 (clk), .resetn (resetn), .start (start), .stop (stop),
        .audio_in_available (avail), .left_channel_audio_in (lch),
        .right_channel_audio_in (rch), .read_audio_in (b_read), .ram_addr (b_addr),
        .ram_data (b_data), .ram_wren (b_wren), .busy (b_busy), .done (b_done),
        .sample_count (b_count)
    );

    typedef struct packed {logic [31:0] l; logic [31:0] r;} smp_t;
    typedef struct packed {logic [AW-1:0] addr; logic [SW-1:0] data;} wr_t;

    smp_t fifo[$];
    smp_t sent[$];
    wr_t  wq_a[$];
    wr_t  wq_b[$];

    int   tests = 0, fails = 0;
    int   cyc = 0, pops = 0, double_pop = 0, acc = 0;
    int   full_cyc = -1, done_cyc = -1;
    logic prev_read = 1'b0, prev_done = 1'b0;

    // RAM-side observer: records every write and pop strobe.
    always @(negedge clk) begin
        cyc++;
        if (a_wren) begin
            wq_a.push_back('{addr: a_addr, data: a_data});
            if (a_addr == AW'(D - 1)) full_cyc = cyc;
        end
        if (b_wren) wq_b.push_back('{addr: b_addr, data: b_data});
        if (a_read) pops++;
        if (a_read && prev_read) double_pop++;
        if (a_done && !prev_done) done_cyc = cyc;
        prev_read = a_read;
        prev_done = a_done;
    end

    // Mono mix is floor((L+R) / 2^27) in -32..31, shifted up by 32 to unsigned.
    function automatic logic [SW-1:0] model_q(logic [31:0] l, logic [31:0] r);
        longint s;
        longint v;
        s = longint'(int'(l)) + longint'(int'(r));
        v = (s >>> 27) + 32;
        return SW'(v);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Controller FIFO model: pops on the strobe, presents the head while non-empty.
    task automatic step();
        @(negedge clk);
        if (a_read && fifo.size() > 0) void'(fifo.pop_front());
        if (fifo.size() > 0 && !a_read) acc++;
        avail = (fifo.size() > 0);
        if (avail) begin
            lch = fifo[0].l;
            rch = fifo[0].r;
        end else begin
            lch = '0;
            rch = '0;
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic push_rand(int n);
        smp_t s;
        sent.delete();
        for (int i = 0; i < n; i++) begin
            s.l = $urandom();
            s.r = $urandom();
            fifo.push_back(s);
            sent.push_back(s);
        end
    endtask

    task automatic push_one(logic [31:0] l, logic [31:0] r);
        smp_t s;
        s.l = l;
        s.r = r;
        fifo.push_back(s);
        sent.push_back(s);
    endtask

    task automatic pulse(logic s, logic p);
        step();
        start = s;
        stop  = p;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic flush();
        fifo.delete();
        run(3);
        wq_a.delete();
        wq_b.delete();
    endtask

    int k;
    logic hit;
    logic [SW-1:0] qexp [4];

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; avail = 1'b0; lch = '0; rch = '0;
        run(3);
        check("rst_read", a_read, 0);
        check("rst_wren", a_wren, 0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_count", a_count, 0);
        resetn = 1'b1;
        run(2);

        // Idle: samples are popped every second cycle and discarded.
        pops = 0; double_pop = 0; wq_a.delete();
        push_rand(6);
        run(20);
        check("idle_pops", pops, 6);
        check("idle_no_back2back", double_pop, 0);
        check("idle_no_writes", wq_a.size(), 0);
        check("idle_busy", a_busy, 0);
        check("idle_count", a_count, 0);
        check("idle_data", a_data, 0);

        // Quantizer corner values through a short take.
        flush();
        pulse(1'b1, 1'b0);
        check("q_busy_after_start", a_busy, 1);
        check("q_done_after_start", a_done, 0);
        sent.delete();
        push_one(32'h0000_0000, 32'h0000_0000);
        push_one(32'h4000_0000, 32'h4000_0000);
        push_one(32'h8000_0000, 32'h8000_0000);
        push_one(32'h7FFF_FFFF, 32'h0000_0000);
        qexp[0] = 6'd32; qexp[1] = 6'd48; qexp[2] = 6'd0; qexp[3] = 6'd47;
        run(12);
        check("q_nwrites", wq_a.size(), 4);
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            check("q_addr", wq_a[i].addr, i);
            check("q_data", wq_a[i].data, qexp[i]);
            check("q_model", model_q(sent[i].l, sent[i].r), qexp[i]);
        end
        check("q3_nwrites", wq_b.size(), 2);
        if (wq_b.size() == 2) check("q3_data1", wq_b[1].data, qexp[3]);
        pulse(1'b0, 1'b1);
        check("q_stop_done", a_done, 1);
        check("q_stop_busy", a_busy, 0);
        check("q_stop_count", a_count, 4);

        // Stop in the write cycle of accept k: that write still lands.
        flush();
        pulse(1'b1, 1'b0);
        k = $urandom_range(2, 6);
        acc = 0;
        push_rand(20);
        for (int t = 0; t < 200 && acc < k + 1; t++) step();
        check("stop_accept_timeout", acc, k + 1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(6);
        check("stop_nwrites", wq_a.size(), k + 1);
        for (int i = 0; i < wq_a.size() && i <= k; i++) begin
            check("stop_addr", wq_a[i].addr, i);
            check("stop_data", wq_a[i].data, model_q(sent[i].l, sent[i].r));
        end
        check("stop_count", a_count, k + 1);
        check("stop_done", a_done, 1);
        check("stop_busy", a_busy, 0);
        check("stop3_nwrites", wq_b.size(), k / 3 + 1);
        check("stop3_count", b_count, k / 3 + 1);
        for (int j = 0; j < wq_b.size() && j <= k / 3; j++)
            check("stop3_data", wq_b[j].data, model_q(sent[3*j].l, sent[3*j].r));

        // start+stop together: start wins.
        flush();
        pulse(1'b1, 1'b1);
        check("ss_busy", a_busy, 1);
        check("ss_done", a_done, 0);
        check("ss_count", a_count, 0);

        // Full take: 10 offered, 8 written, DONE the cycle after address D-1.
        wq_a.delete(); wq_b.delete();
        full_cyc = -1; done_cyc = -1; pops = 0;
        push_rand(10);
        run(30);
        check("full_nwrites", wq_a.size(), D);
        for (int i = 0; i < wq_a.size() && i < D; i++) begin
            check("full_addr", wq_a[i].addr, i);
            check("full_data", wq_a[i].data, model_q(sent[i].l, sent[i].r));
        end
        check("full_count", a_count, D);
        check("full_done", a_done, 1);
        check("full_busy", a_busy, 0);
        check("full_done_timing", done_cyc, full_cyc + 1);
        check("full_pops", pops, 10);
        check("full3_nwrites", wq_b.size(), 4);
        check("full3_busy", b_busy, 1);

        // Decimation by 3: samples 0, 3, 6 land at addresses 0..2.
        flush();
        pulse(1'b1, 1'b0);
        push_rand(9);
        run(30);
        check("dec_nwrites", wq_b.size(), 3);
        for (int j = 0; j < wq_b.size() && j < 3; j++) begin
            check("dec_addr", wq_b[j].addr, j);
            check("dec_data", wq_b[j].data, model_q(sent[3*j].l, sent[3*j].r));
        end
        check("dec_count", b_count, 3);
        check("dec_full_side", wq_a.size(), D);

        // Asynchronous reset during the write to address 5.
        flush();
        pulse(1'b1, 1'b0);
        push_rand(20);
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            step();
            if (a_wren && a_addr == AW'(5)) hit = 1'b1;
        end
        check("arst_reached_addr5", hit, 1);
        #1 resetn = 1'b0;
        #1;
        check("arst_wren", a_wren, 0);
        check("arst_busy", a_busy, 0);
        check("arst_count", a_count, 0);
        check("arst_read", a_read, 0);
        fifo.delete();
        run(2);
        resetn = 1'b1;
        run(2);
        check("arst_idle_done", a_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
